// File: rtl/riscv_pkg.sv
// Shared register-file definitions: default sizes, register address type and
// the clear/run state encoding used by regfile_mp.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef logic [AW-1:0] reg_addr_t;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_rdport.sv
// One read port: x0 mask, busy lookup and, with REGFILE_BYPASS_EN defined,
// forwarding of the in-flight writeback so read-after-write costs no cycle.
module regfile_rdport #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            run,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] stored_data,
  input  logic            stored_busy,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            busy_set,
  input  logic [AW-1:0]   busy_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_busy
);

`ifndef REGFILE_BYPASS_EN
  // Writeback and issue strobes only matter to the forwarding path.
  logic unused_bypass;
  assign unused_bypass = &{1'b0, wr_en, wr_addr, wr_data, busy_set, busy_addr};
`endif

  always_comb begin
    rd_data = '0;
    rd_busy = 1'b0;
    if (run && (rd_addr != '0)) begin
      rd_data = stored_data;
      rd_busy = stored_busy;
`ifdef REGFILE_BYPASS_EN
      // wr_en/busy_set arrive already qualified with RUN and a nonzero address.
      if (wr_en && (wr_addr == rd_addr)) begin
        rd_data = wr_data;
        rd_busy = busy_set && (busy_addr == rd_addr);
      end
`endif
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with busy scoreboard and post-reset clear
// sequencer. Optional same-cycle write forwarding: define REGFILE_BYPASS_EN.
module regfile_mp
  import riscv_pkg::rf_state_e;
  import riscv_pkg::RF_CLEAR;
  import riscv_pkg::RF_RUN;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = riscv_pkg::NREGS,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready_o,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic                wr_en_i,
  input  logic [AW-1:0]       wr_addr_i,
  input  logic [XLEN-1:0]     wr_data_i,
  input  logic                busy_set_i,
  input  logic [AW-1:0]       busy_addr_i
);

  rf_state_e        state_reg, state_next;
  logic [AW-1:0]    clr_ptr_reg, clr_ptr_next;
  logic [XLEN-1:0]  regs_reg [NREGS];
  logic [NREGS-1:0] busy_reg;

  logic            run;
  logic            wr_hit;
  logic            set_hit;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;

  assign run     = (state_reg == RF_RUN);
  assign ready_o = run;
  assign wr_hit  = run && wr_en_i && (wr_addr_i != '0);
  assign set_hit = run && busy_set_i && (busy_addr_i != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= RF_CLEAR;
      clr_ptr_reg <= AW'(1);
    end else begin
      state_reg   <= state_next;
      clr_ptr_reg <= clr_ptr_next;
    end
  end

  // The clear sequencer borrows the single write port, so x1..x(NREGS-1)
  // are zeroed one per cycle before writeback is allowed in.
  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    mem_we       = 1'b0;
    mem_waddr    = wr_addr_i;
    mem_wdata    = wr_data_i;
    case (state_reg)
      RF_CLEAR: begin
        mem_we       = 1'b1;
        mem_waddr    = clr_ptr_reg;
        mem_wdata    = '0;
        clr_ptr_next = clr_ptr_reg + 1'b1;
        if (clr_ptr_reg == AW'(NREGS - 1)) begin
          state_next = RF_RUN;
        end
      end
      RF_RUN: begin
        mem_we = wr_hit;
      end
      default: begin
        state_next = RF_CLEAR;
      end
    endcase
  end

  // x0 storage is never written; every read port masks it to zero.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      regs_reg[mem_waddr] <= mem_wdata;
    end
  end

  // Issue after writeback in this block so a same-edge set wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= '0;
    end else begin
      if (wr_hit) begin
        busy_reg[wr_addr_i] <= 1'b0;
      end
      if (set_hit) begin
        busy_reg[busy_addr_i] <= 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rdport
      logic [AW-1:0] port_addr;
      assign port_addr = rd_addr_i[gi*AW +: AW];

      regfile_rdport #(
        .XLEN(XLEN),
        .AW  (AW)
      ) u_rdport (
        .run        (run),
        .rd_addr    (port_addr),
        .stored_data(regs_reg[port_addr]),
        .stored_busy(busy_reg[port_addr]),
        .wr_en      (wr_hit),
        .wr_addr    (wr_addr_i),
        .wr_data    (wr_data_i),
        .busy_set   (set_hit),
        .busy_addr  (busy_addr_i),
        .rd_data    (rd_data_o[gi*XLEN +: XLEN]),
        .rd_busy    (rd_busy_o[gi])
      );
    end
  endgenerate

endmodule
